// File: rtl/decode_issue_stage_pkg.sv
// Shared types and the pure RV32I decode function for the decode/issue stage.
package decode_issue_stage_pkg;

    localparam int unsigned Xlen = 32;

    // Major opcode field, instr[6:0] including the 2'b11 length bits.
    typedef enum logic [6:0] {
        OpLoad    = 7'b0000011,
        OpMiscMem = 7'b0001111,
        OpOpImm   = 7'b0010011,
        OpAuipc   = 7'b0010111,
        OpStore   = 7'b0100011,
        OpOp      = 7'b0110011,
        OpLui     = 7'b0110111,
        OpBranch  = 7'b1100011,
        OpJalr    = 7'b1100111,
        OpJal     = 7'b1101111
    } opcode_e;

    // ALU opcode: {is_branch, funct7[5] or 1 for branches, funct3}.
    typedef enum logic [4:0] {
        AluAdd  = 5'b00000,
        AluSll  = 5'b00001,
        AluSlt  = 5'b00010,
        AluSltu = 5'b00011,
        AluXor  = 5'b00100,
        AluSrl  = 5'b00101,
        AluOr   = 5'b00110,
        AluAnd  = 5'b00111,
        AluSub  = 5'b01000,
        AluSra  = 5'b01101,
        AluBeq  = 5'b11000,
        AluBne  = 5'b11001,
        AluBlt  = 5'b11100,
        AluBge  = 5'b11101,
        AluBltu = 5'b11110,
        AluBgeu = 5'b11111
    } alu_op_e;

    typedef struct packed {
        alu_op_e         alu_op;
        logic [Xlen-1:0] op_a;
        logic [Xlen-1:0] op_b;
        logic [4:0]      rd;
        logic            rd_we;
        logic            branch;
        logic            jump;
        logic [Xlen-1:0] target;
        logic [Xlen-1:0] pc;
        logic            illegal;
    } issue_bundle_t;

    function automatic issue_bundle_t decode(input logic [31:0]     instr,
                                             input logic [Xlen-1:0] pc,
                                             input logic [Xlen-1:0] rs1,
                                             input logic [Xlen-1:0] rs2);
        issue_bundle_t   b;
        logic            legal;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic [Xlen-1:0] imm_i;
        logic [Xlen-1:0] imm_s;
        logic [Xlen-1:0] imm_b;
        logic [Xlen-1:0] imm_u;
        logic [Xlen-1:0] imm_j;
        logic [Xlen-1:0] jalr_sum;

        f3    = instr[14:12];
        f7    = instr[31:25];
        imm_i = {{(Xlen-12){instr[31]}}, instr[31:20]};
        imm_s = {{(Xlen-12){instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{(Xlen-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{(Xlen-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        jalr_sum = rs1 + imm_i;

        b        = '0;
        b.alu_op = AluAdd;
        b.rd     = instr[11:7];
        b.pc     = pc;
        legal    = 1'b1;

        case (instr[6:0])
            OpOp: begin
                legal   = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                b.alu_op = alu_op_e'({1'b0, f7[5], f3});
                b.op_a  = rs1;
                b.op_b  = rs2;
                b.rd_we = 1'b1;
            end
            OpOpImm: begin
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'h00);
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20);
                end
                b.alu_op = alu_op_e'({1'b0, (f3 == 3'b101) ? f7[5] : 1'b0, f3});
                b.op_a   = rs1;
                // Shifts carry only shamt; the upper immediate bits select SRL/SRA.
                b.op_b   = ((f3 == 3'b001) || (f3 == 3'b101)) ?
                           {{(Xlen-5){1'b0}}, instr[24:20]} : imm_i;
                b.rd_we  = 1'b1;
            end
            OpBranch: begin
                legal    = (f3 != 3'b010) && (f3 != 3'b011);
                b.alu_op = alu_op_e'({2'b11, f3});
                b.op_a   = rs1;
                b.op_b   = rs2;
                b.branch = 1'b1;
                b.target = pc + imm_b;
            end
            OpLui: begin
                b.op_b  = imm_u;
                b.rd_we = 1'b1;
            end
            OpAuipc: begin
                b.op_a  = pc;
                b.op_b  = imm_u;
                b.rd_we = 1'b1;
            end
            OpJal: begin
                b.op_a   = pc;
                b.op_b   = Xlen'(4);
                b.target = pc + imm_j;
                b.jump   = 1'b1;
                b.rd_we  = 1'b1;
            end
            OpJalr: begin
                legal    = (f3 == 3'b000);
                b.op_a   = pc;
                b.op_b   = Xlen'(4);
                b.target = {jalr_sum[Xlen-1:1], 1'b0};
                b.jump   = 1'b1;
                b.rd_we  = 1'b1;
            end
            OpLoad: begin
                b.op_a  = rs1;
                b.op_b  = imm_i;
                b.rd_we = 1'b1;
            end
            OpStore: begin
                b.op_a = rs1;
                b.op_b = imm_s;
            end
            OpMiscMem: begin
                // Fences are NOPs in this pipeline.
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            b.alu_op  = AluAdd;
            b.op_a    = '0;
            b.op_b    = '0;
            b.rd_we   = 1'b0;
            b.branch  = 1'b0;
            b.jump    = 1'b0;
            b.target  = '0;
            b.illegal = 1'b1;
        end

        if (b.rd == 5'd0) begin
            b.rd_we = 1'b0;
        end
        return b;
    endfunction

endpackage

// File: rtl/decode_issue_stage_skid_buffer.sv
// Two-entry skid buffer: main output register plus one overflow entry, so the
// upstream ready can be a flop while still sustaining one transfer per cycle.
module decode_issue_stage_skid_buffer #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    input  logic flush_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    T     main_data_q, main_data_d;
    T     skid_data_q, skid_data_d;
    logic in_fire;
    logic main_free;

    assign in_ready_o  = !skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign in_fire     = in_valid_i && in_ready_o;
    assign main_free   = !main_valid_q || out_ready_i;

    // Next-state: refill main from skid first (FIFO order), else from input.
    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_data_d = in_data_i;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data_i;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: decodes on the way in, buffers the bundle for execute.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [4:0]      alu_op_o,
    output logic [XLEN-1:0] op_a_o,
    output logic [XLEN-1:0] op_b_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] pc_o,
    output logic            illegal_o
);

    issue_bundle_t dec_bundle;
    issue_bundle_t held_bundle;
    logic          held_valid;

    assign dec_bundle = decode(instr_i, pc_i, rs1_data_i, rs2_data_i);

    decode_issue_stage_skid_buffer #(
        .T (issue_bundle_t)
    ) u_skid_buffer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (dec_bundle),
        .flush_i     (flush_i),
        .out_valid_o (held_valid),
        .out_ready_i (out_ready_i),
        .out_data_o  (held_bundle)
    );

    assign out_valid_o = held_valid;

    // Present the held bundle when valid, otherwise an idle NOP at RESET_PC.
    always_comb begin
        if (held_valid) begin
            alu_op_o  = held_bundle.alu_op;
            op_a_o    = held_bundle.op_a;
            op_b_o    = held_bundle.op_b;
            rd_addr_o = held_bundle.rd;
            rd_we_o   = held_bundle.rd_we;
            branch_o  = held_bundle.branch;
            jump_o    = held_bundle.jump;
            target_o  = held_bundle.target;
            pc_o      = held_bundle.pc;
            illegal_o = held_bundle.illegal;
        end else begin
            alu_op_o  = AluAdd;
            op_a_o    = '0;
            op_b_o    = '0;
            rd_addr_o = '0;
            rd_we_o   = 1'b0;
            branch_o  = 1'b0;
            jump_o    = 1'b0;
            target_o  = '0;
            pc_o      = RESET_PC;
            illegal_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: the driver queues hand-computed
// bundles as instructions are accepted, the monitor checks every presented bundle.
`timescale 1ns/1ps
module tb_decode_issue_stage;
    import decode_issue_stage_pkg::*;

    localparam logic [31:0] ResetPc = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] instr, pc, rs1, rs2;
    logic [4:0]  alu_op, rd_addr;
    logic [31:0] op_a, op_b, target, pc_out;
    logic        rd_we, branch, jump, illegal;

    always #5 clk = ~clk;

    decode_issue_stage #(
        .XLEN     (32),
        .RESET_PC (ResetPc)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .pc_i        (pc),
        .rs1_data_i  (rs1),
        .rs2_data_i  (rs2),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .alu_op_o    (alu_op),
        .op_a_o      (op_a),
        .op_b_o      (op_b),
        .rd_addr_o   (rd_addr),
        .rd_we_o     (rd_we),
        .branch_o    (branch),
        .jump_o      (jump),
        .target_o    (target),
        .pc_o        (pc_out),
        .illegal_o   (illegal)
    );

    typedef struct {
        logic [31:0]   instr;
        logic [31:0]   pc;
        logic [31:0]   rs1;
        logic [31:0]   rs2;
        issue_bundle_t exp;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            stalls = 0;
    issue_bundle_t exp_q[$];
    vec_t          vecs[14];

    function automatic issue_bundle_t mk(alu_op_e op, logic [31:0] a, logic [31:0] b,
                                         logic [4:0] rd, logic we, logic br, logic j,
                                         logic [31:0] tgt, logic [31:0] p, logic ill);
        issue_bundle_t r;
        r.alu_op = op;  r.op_a = a;    r.op_b = b;     r.rd = rd;     r.rd_we = we;
        r.branch = br;  r.jump = j;    r.target = tgt; r.pc = p;      r.illegal = ill;
        return r;
    endfunction

    task automatic setv(int i, logic [31:0] ins, logic [31:0] p, logic [31:0] a,
                        logic [31:0] b, issue_bundle_t e);
        vecs[i].instr = ins; vecs[i].pc = p; vecs[i].rs1 = a; vecs[i].rs2 = b;
        vecs[i].exp = e;
    endtask

    task automatic check_word(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one instruction from posedge+1 until accepted; queue its expectation.
    task automatic send(int idx);
        int n;
        bit acc;
        in_valid = 1'b1;
        instr = vecs[idx].instr; pc = vecs[idx].pc;
        rs1 = vecs[idx].rs1;     rs2 = vecs[idx].rs2;
        n = 0; acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                acc = 1'b1;
                exp_q.push_back(vecs[idx].exp);
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout vec %0d: never accepted, want accepted", idx);
        end
    endtask

    task automatic wait_drain(string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d bundles outstanding, want 0", name, exp_q.size());
        end
        @(negedge clk);
        check_word({name, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every presented bundle with the queue head, pop on transfer.
    always @(negedge clk) begin
        issue_bundle_t act;
        issue_bundle_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && flush === 1'b0) begin
            act = mk(alu_op_e'(alu_op), op_a, op_b, rd_addr, rd_we, branch, jump, target,
                     pc_out, illegal);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bundle_unexpected: got pc=%h alu=%b, want no output", pc_out,
                         alu_op);
            end else begin
                e = exp_q[0];
                if (act !== e) begin
                    errors++;
                    $display("FAIL bundle pc=%h: got alu=%b a=%h b=%h rd=%0d we=%b br=%b j=%b tgt=%h pc=%h ill=%b want alu=%b a=%h b=%h rd=%0d we=%b br=%b j=%b tgt=%h pc=%h ill=%b",
                             e.pc, act.alu_op, act.op_a, act.op_b, act.rd, act.rd_we,
                             act.branch, act.jump, act.target, act.pc, act.illegal,
                             e.alu_op, e.op_a, e.op_b, e.rd, e.rd_we, e.branch, e.jump,
                             e.target, e.pc, e.illegal);
                end
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1 = '0; rs2 = '0;

        //             instr          pc            rs1           rs2
        setv(0,  32'h002081B3, 32'h0000_0000, 32'h5,        32'h7,
             mk(AluAdd,  32'h5, 32'h7, 5'd3, 1, 0, 0, 32'h0, 32'h0, 0));
        setv(1,  32'h402081B3, 32'h0000_0004, 32'h8000_0000, 32'h7,
             mk(AluSub,  32'h8000_0000, 32'h7, 5'd3, 1, 0, 0, 32'h0, 32'h4, 0));
        setv(2,  32'h40335293, 32'h0000_0008, 32'h8000_0000, 32'h0,
             mk(AluSra,  32'h8000_0000, 32'h3, 5'd5, 1, 0, 0, 32'h0, 32'h8, 0));
        setv(3,  32'h00208463, 32'h0000_0100, 32'h11,       32'h22,
             mk(AluBeq,  32'h11, 32'h22, 5'd8, 0, 1, 0, 32'h108, 32'h100, 0));
        setv(4,  32'h402091B3, 32'h0000_0104, 32'h1,        32'h2,
             mk(AluAdd,  32'h0, 32'h0, 5'd3, 0, 0, 0, 32'h0, 32'h104, 1));
        setv(5,  32'h008000EF, 32'hFFFF_FFFC, 32'h0,        32'h0,
             mk(AluAdd,  32'hFFFF_FFFC, 32'h4, 5'd1, 1, 0, 1, 32'h4, 32'hFFFF_FFFC, 0));
        setv(6,  32'h003100E7, 32'h0000_0200, 32'h1000,     32'h0,
             mk(AluAdd,  32'h200, 32'h4, 5'd1, 1, 0, 1, 32'h1002, 32'h200, 0));
        setv(7,  32'h123453B7, 32'h0000_0204, 32'hAAAA,     32'h0,
             mk(AluAdd,  32'h0, 32'h1234_5000, 5'd7, 1, 0, 0, 32'h0, 32'h204, 0));
        setv(8,  32'h00000013, 32'h0000_0208, 32'h55,       32'h0,
             mk(AluAdd,  32'h55, 32'h0, 5'd0, 0, 0, 0, 32'h0, 32'h208, 0));
        setv(9,  32'h00000001, 32'h0000_020C, 32'h1,        32'h1,
             mk(AluAdd,  32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0, 32'h20C, 1));
        setv(10, 32'h0020A623, 32'h0000_0210, 32'h1000,     32'h5,
             mk(AluAdd,  32'h1000, 32'hC, 5'd12, 0, 0, 0, 32'h0, 32'h210, 0));
        setv(11, 32'hFFC0A203, 32'h0000_0214, 32'h1000,     32'h0,
             mk(AluAdd,  32'h1000, 32'hFFFF_FFFC, 5'd4, 1, 0, 0, 32'h0, 32'h214, 0));
        setv(12, 32'h00001497, 32'h0000_0300, 32'h0,        32'h0,
             mk(AluAdd,  32'h300, 32'h1000, 5'd9, 1, 0, 0, 32'h0, 32'h300, 0));
        setv(13, 32'hFE20EEE3, 32'h0000_0400, 32'h3,        32'h9,
             mk(AluBltu, 32'h3, 32'h9, 5'd29, 0, 1, 0, 32'h3FC, 32'h400, 0));

        // Reset state.
        #12;
        check_word("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_word("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check_word("rst_alu_op",    {27'b0, alu_op},    32'd0);
        check_word("rst_op_a",      op_a,               32'd0);
        check_word("rst_op_b",      op_b,               32'd0);
        check_word("rst_target",    target,             32'd0);
        check_word("rst_pc",        pc_out,             ResetPc);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Streaming with execute always ready: 1-cycle latency, no stalls.
        out_ready = 1'b1;
        stalls = 0;
        send(0);
        in_valid = 1'b0;
        @(negedge clk);
        check_word("latency_out_valid", {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i < 14; i++) send(i);
        in_valid = 1'b0;
        check_word("stream_stalls", stalls, 32'd0);
        wait_drain("stream");

        // Back-pressure: two held, ready drops, FIFO order after release.
        out_ready = 1'b0;
        send(1);
        send(2);
        in_valid = 1'b0;
        @(negedge clk);
        check_word("bp_in_ready_low",  {31'b0, in_ready},  32'd0);
        check_word("bp_out_valid",     {31'b0, out_valid}, 32'd1);
        @(posedge clk); #1;
        fork
            begin
                send(3);
                send(4);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(negedge clk);
                check_word("bp_hold_in_ready", {31'b0, in_ready}, 32'd0);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        wait_drain("backpressure");

        // Flush with both entries full and an input offered.
        out_ready = 1'b0;
        send(5);
        send(6);
        instr = vecs[7].instr; pc = vecs[7].pc; rs1 = vecs[7].rs1; rs2 = vecs[7].rs2;
        in_valid = 1'b1; flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_word("flush_full_out_valid", {31'b0, out_valid}, 32'd0);
        check_word("flush_full_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk); #1;

        // Flush with main full and a transfer that must be dropped.
        send(8);
        instr = vecs[9].instr; pc = vecs[9].pc; rs1 = vecs[9].rs1; rs2 = vecs[9].rs2;
        in_valid = 1'b1; flush = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_word("flush_drop_out_valid", {31'b0, out_valid}, 32'd0);
        check_word("flush_drop_in_ready",  {31'b0, in_ready},  32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(10);
        in_valid = 1'b0;
        wait_drain("after_flush");

        // Asynchronous reset mid-stream clears the output immediately.
        out_ready = 1'b0;
        send(11);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_word("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_word("async_rst_pc",        pc_out,             ResetPc);
        exp_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(12);
        in_valid = 1'b0;
        wait_drain("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
Name: decode_issue_stage

Overview:
- RV32I decode/issue stage that sits directly upstream of the ALU.
- Accepts fetched instructions on a valid/ready handshake, decodes each into an aluops opcode plus selected operands, and holds the result in a pipeline register for the execute stage.
- Upstream ready is registered: a 2-entry skid buffer breaks the ready path so full throughput holds under back-pressure.
- Pipeline flush is supported for branch redirects.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, value driven on pc_o while out_valid_o=0 after reset.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  upstream instruction valid
- in_ready_o  out  1  stage can accept (registered)
- instr_i  in  32  instruction word
- pc_i  in  XLEN  instruction address
- rs1_data_i  in  XLEN  register file read port 1, same cycle as instr_i
- rs2_data_i  in  XLEN  register file read port 2, same cycle as instr_i
- flush_i  in  1  discard all held and incoming instructions
- out_valid_o  out  1  decoded bundle valid
- out_ready_i  in  1  execute stage accepts
- alu_op_o  out  5  aluops opcode
- op_a_o  out  XLEN  ALU operand A
- op_b_o  out  XLEN  ALU operand B
- rd_addr_o  out  5  destination register
- rd_we_o  out  1  writeback enable (forced 0 when rd=0)
- branch_o  out  1  conditional branch (alu_op_o[4]=1)
- jump_o  out  1  JAL/JALR
- target_o  out  XLEN  branch/jump target
- pc_o  out  XLEN  pc of the bundle
- illegal_o  out  1  instruction not decodable

Behaviour:
- Reset (async, rst_ni=0):
  - both buffer entries invalid, so out_valid_o=0 and in_ready_o=1 from the first edge after release;
  - alu_op_o=ADD, all data outputs 0, pc_o=RESET_PC.
- Handshake:
  - Transfer occurs on valid&ready, on both sides.
  - in_ready_o = !skid_valid, registered.
  - Latency is 1 cycle from an input transfer to out_valid_o when the main register is empty or draining.
  - out_valid_o stays high and all bundle outputs stay stable until out_ready_i.
- Skid buffer:
  - An input accepted while the main register holds data and out_ready_i=0 goes to the skid entry; in_ready_o drops next cycle.
  - When the main register drains, the skid entry moves to main and in_ready_o rises next cycle.
  - Order is strictly FIFO. Simultaneous input accept and output drain keeps 1 instruction per cycle.
- Flush:
  - flush_i=1 invalidates main and skid at the edge. An input transfer in the same cycle is dropped (flush wins).
  - Next cycle: out_valid_o=0, in_ready_o=1.
- Decode (f3=funct3, f7=funct7):
  - OP 0110011: alu_op={0,f7[5],f3}. Legal only if f7=0x00, or f7=0x20 with f3 in {000,101}. A=rs1, B=rs2, rd_we=1.
  - OP-IMM 0010011: alu_op={0,(f3==101)?f7[5]:0,f3}. Shifts require f7 in {0x00,0x20(only f3=101)}. A=rs1, B=sext(I-imm), rd_we=1.
  - BRANCH 1100011: alu_op={1,1,f3}; f3 in {010,011} is illegal. A=rs1, B=rs2, target=pc+B-imm, rd_we=0.
  - LUI: ADD, A=0, B=U-imm. AUIPC: ADD, A=pc, B=U-imm.
  - JAL: ADD, A=pc, B=4, target=pc+J-imm, jump. JALR (f3=000): ADD, A=pc, B=4, target=(rs1+I-imm)&~1, jump.
  - LOAD/STORE: ADD, A=rs1, B=sext(I/S-imm); rd_we=1 for LOAD only.
  - MISC-MEM: NOP (ADD, rd_we=0).
  - Anything else, including instr_i[1:0]!=11: illegal_o=1, alu_op=ADD, rd_we=0, branch=jump=0.
  - Illegal bundles still pass through the handshake.
- Width rule: all adds are modulo 2^XLEN and wrap silently (e.g. pc=FFFF_FFFC, JAL imm +8 gives target 0000_0004).

Decomposition:
- ALUOps package gains typedefs for the opcode field (7'b0110011 etc.) and an issue_bundle_t packed struct (alu_op, op_a, op_b, rd, rd_we, branch, jump, target, pc, illegal).
- Decode is a pure function in that package.
- One sub-module: skid_buffer, parameterized on bundle type, 2 entries, with valid/ready and flush.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready_i=1 -> next cycle out_valid_o=1, alu_op=ADD, A=5, B=7, rd=3, rd_we=1.
- sub x3,x1,x2 (0x402081B3) then srai x5,x6,3 (0x40335293), rs1=0x80000000 -> SUB then SRA with B=3, rd=5.
- beq x1,x2,+8 (0x00208463) at pc=0x100 -> alu_op=BEQ (11000), branch_o=1, target=0x108, rd_we=0.
- 0x402091B3 (sll with f7=0x20) -> illegal_o=1, rd_we=0, handshake completes.
- out_ready_i=0 for 3 cycles with a back-to-back stream -> exactly 2 held, in_ready_o=0 one cycle after the second accept; release yields the original order, none lost or duplicated.
- Buffer full plus in_valid_i=1 and flush_i=1 in the same cycle -> next cycle out_valid_o=0, in_ready_o=1, no flushed instruction ever appears. Async reset asserted mid-stream -> out_valid_o=0 immediately.
